// File: rtl/pipeline_pkg.sv
// Types and constants shared by the pipeline stages.
package pipeline_pkg;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {pc, instr} entries; clear wins over push and pop.
module fetch_queue
    import pipeline_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    output fetch_entry_t  head,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    // A push into a full queue is only legal when the head leaves in the same cycle.
    assign do_pop  = pop & (count != '0);
    assign do_push = push & ((count != CW'(DEPTH)) | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pipeline_if_stage.sv
// Instruction-fetch stage: fetch PC, single-outstanding imem requests, fetch queue
// towards IDR, and EXB redirect handling with wrong-path response squashing.
module pipeline_if_stage
    import pipeline_pkg::*;
#(
    parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          FQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken_EXB,
    input  logic [63:0] branch_target_EXB,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid_IF,
    output logic [63:0] pc_IF,
    output logic [31:0] instr_IF
);

    localparam int            CW       = $clog2(FQ_DEPTH) + 1;
    localparam logic [CW:0]   FQ_LIMIT = (CW + 1)'(FQ_DEPTH);

    logic [63:0]   fetch_pc;
    logic [63:0]   outst_pc;
    logic          outst;
    logic          stale;
    logic          live;
    logic          grant;
    logic          rsp;
    logic          push;
    logic          pop;
    logic [CW-1:0] count;
    logic [CW:0]   occupancy;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;
    logic          unused_target_lsbs;

    // imem handshake: a request is accepted in any cycle with imem_req & imem_gnt;
    // each accepted request returns exactly one imem_rvalid in a later cycle.
    assign live      = outst & ~stale;
    assign rsp       = outst & imem_rvalid;
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, live};

    // Space check counts the live in-flight response but not a same-cycle pop.
    assign imem_req  = reset & ~branch_taken_EXB & (~outst | imem_rvalid) &
                       (occupancy < FQ_LIMIT);
    assign imem_addr = fetch_pc;
    assign grant     = imem_req & imem_gnt;

    assign push       = rsp & ~stale & ~branch_taken_EXB;
    assign push_entry = '{pc: outst_pc, instr: imem_rdata};
    assign pop        = instr_valid_IF & ~stall;

    assign instr_valid_IF = (count != '0) & ~branch_taken_EXB;
    assign pc_IF          = instr_valid_IF ? head.pc    : 64'h0;
    assign instr_IF       = instr_valid_IF ? head.instr : 32'h0;

    assign unused_target_lsbs = ^branch_target_EXB[1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= {RESET_PC[63:2], 2'b00};
            outst_pc <= 64'h0;
            outst    <= 1'b0;
            stale    <= 1'b0;
        end else if (branch_taken_EXB) begin
            fetch_pc <= {branch_target_EXB[63:2], 2'b00};
            // A wrong-path response still owed by memory must be swallowed later.
            if (outst && !imem_rvalid) begin
                stale <= 1'b1;
            end else begin
                outst <= 1'b0;
                stale <= 1'b0;
            end
        end else if (grant) begin
            outst    <= 1'b1;
            stale    <= 1'b0;
            outst_pc <= fetch_pc;
            fetch_pc <= fetch_pc + 64'd4;
        end else if (rsp) begin
            outst <= 1'b0;
            stale <= 1'b0;
        end
    end

    fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk       (clk),
        .reset     (reset),
        .clear     (branch_taken_EXB),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

endmodule

// File: tb/tb_pipeline_if_stage.sv
// Directed bench for pipeline_if_stage with a single-outstanding imem responder model.
module tb_pipeline_if_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken_EXB;
    logic [63:0] branch_target_EXB;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid_IF;
    logic [63:0] pc_IF;
    logic [31:0] instr_IF;

    int vectors     = 0;
    int miscompares = 0;

    // memory responder state
    logic        pend;
    logic [63:0] pend_addr;
    int          pend_cnt;
    int          mem_lat;
    logic        gnt_en;

    pipeline_if_stage dut (
        .clk               (clk),
        .reset             (reset),
        .stall             (stall),
        .branch_taken_EXB  (branch_taken_EXB),
        .branch_target_EXB (branch_target_EXB),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_gnt          (imem_gnt),
        .imem_rvalid       (imem_rvalid),
        .imem_rdata        (imem_rdata),
        .instr_valid_IF    (instr_valid_IF),
        .pc_IF             (pc_IF),
        .instr_IF          (instr_IF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return {a[23:0], 8'h13};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_gnt(input logic en);
        gnt_en   = en;
        imem_gnt = en & ~pend;
    endtask

    // Close the current cycle: capture a grant, cross the edge, drive memory outputs.
    task automatic advance();
        if (imem_req && imem_gnt) begin
            pend      = 1'b1;
            pend_addr = imem_addr;
            pend_cnt  = mem_lat;
        end
        @(posedge clk);
        #1;
        imem_rvalid       = 1'b0;
        imem_rdata        = 32'h0;
        branch_taken_EXB  = 1'b0;
        branch_target_EXB = 64'h0;
        if (pend) begin
            pend_cnt = pend_cnt - 1;
            if (pend_cnt == 0) begin
                pend        = 1'b0;
                imem_rvalid = 1'b1;
                imem_rdata  = instr_of(pend_addr);
            end
        end
        imem_gnt = gnt_en & ~pend;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic redirect(input logic [63:0] target);
        branch_taken_EXB  = 1'b1;
        branch_target_EXB = target;
    endtask

    // Returns at the negedge of the first cycle after reset release.
    task automatic do_reset();
        reset             = 1'b0;
        stall             = 1'b0;
        branch_taken_EXB  = 1'b0;
        branch_target_EXB = 64'h0;
        imem_rvalid       = 1'b0;
        imem_rdata        = 32'h0;
        pend              = 1'b0;
        pend_cnt          = 0;
        mem_lat           = 1;
        set_gnt(1'b1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        settle();
    endtask

    task automatic check_head(input string tag, input logic [63:0] pc);
        chk({tag, "_valid"}, instr_valid_IF, 1);
        chk({tag, "_pc"}, pc_IF, pc);
        chk({tag, "_instr"}, instr_IF, instr_of(pc));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: observed no end of run, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; stall = 1'b0; branch_taken_EXB = 1'b0; branch_target_EXB = 64'h0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0; imem_gnt = 1'b1;
        pend = 1'b0; pend_addr = 64'h0; pend_cnt = 0; mem_lat = 1; gnt_en = 1'b1;

        // reset values
        settle();
        chk("rst_req", imem_req, 0);
        chk("rst_valid", instr_valid_IF, 0);
        chk("rst_pc", pc_IF, 0);
        chk("rst_instr", instr_IF, 0);

        // sequential fetch, 1-cycle memory
        do_reset();
        chk("a_c0_req", imem_req, 1);
        chk("a_c0_addr", imem_addr, 64'h0);
        chk("a_c0_valid", instr_valid_IF, 0);
        advance(); settle();
        chk("a_c1_addr", imem_addr, 64'h4);
        chk("a_c1_valid", instr_valid_IF, 0);
        advance(); settle();
        check_head("a_c2", 64'h0);
        chk("a_c2_addr", imem_addr, 64'h8);
        advance(); settle();
        check_head("a_c3", 64'h4);
        advance(); settle();
        check_head("a_c4", 64'h8);
        chk("a_c4_addr", imem_addr, 64'h10);

        // stall fills the queue, then drains in order
        do_reset();
        stall = 1'b1;
        repeat (4) begin advance(); settle(); end
        chk("b_c4_req", imem_req, 0);
        repeat (3) begin advance(); settle(); end
        chk("b_c7_req", imem_req, 0);
        check_head("b_c7", 64'h0);
        repeat (3) begin advance(); settle(); end
        check_head("b_c10", 64'h0);
        advance(); stall = 1'b0; settle();
        check_head("b_c10r", 64'h0);
        chk("b_c10_req", imem_req, 0);
        advance(); settle();
        check_head("b_c11", 64'h4);
        chk("b_c11_req", imem_req, 1);
        chk("b_c11_addr", imem_addr, 64'h10);
        advance(); settle();
        check_head("b_c12", 64'h8);
        advance(); settle();
        check_head("b_c13", 64'hC);
        advance(); settle();
        check_head("b_c14", 64'h10);

        // redirect (with stall) while queue holds 0x8, 0xC and nothing in flight
        do_reset();
        stall = 1'b1;
        repeat (4) begin advance(); settle(); end
        set_gnt(1'b0);
        advance(); stall = 1'b0; settle();
        check_head("c_c5", 64'h0);
        advance(); settle();
        check_head("c_c6", 64'h4);
        advance();
        set_gnt(1'b1);
        stall = 1'b1;
        redirect(64'h100);
        settle();
        chk("c_c7_valid", instr_valid_IF, 0);
        chk("c_c7_pc", pc_IF, 0);
        chk("c_c7_req", imem_req, 0);
        advance(); stall = 1'b0; settle();
        chk("c_c8_valid", instr_valid_IF, 0);
        chk("c_c8_req", imem_req, 1);
        chk("c_c8_addr", imem_addr, 64'h100);
        advance(); settle();
        chk("c_c9_valid", instr_valid_IF, 0);
        advance(); settle();
        check_head("c_c10", 64'h100);

        // redirect to unaligned 0x203 with request 0x10 in flight (3-cycle response)
        do_reset();
        repeat (4) begin advance(); settle(); end
        chk("d_c4_addr", imem_addr, 64'h10);
        mem_lat = 3;
        advance(); redirect(64'h203); settle();
        chk("d_c5_valid", instr_valid_IF, 0);
        chk("d_c5_req", imem_req, 0);
        advance(); settle();
        chk("d_c6_req", imem_req, 0);
        advance(); settle();
        chk("d_c7_rvalid_stale", imem_rvalid, 1);
        chk("d_c7_req", imem_req, 1);
        chk("d_c7_addr", imem_addr, 64'h200);
        chk("d_c7_valid", instr_valid_IF, 0);
        mem_lat = 1;
        advance(); settle();
        chk("d_c8_valid", instr_valid_IF, 0);
        advance(); settle();
        check_head("d_c9", 64'h200);

        // redirect coinciding with a response, then fetch_pc wrap-around
        advance(); redirect(64'hFFFF_FFFF_FFFF_FFFC); settle();
        chk("e_c10_req", imem_req, 0);
        advance(); settle();
        chk("e_c11_valid", instr_valid_IF, 0);
        chk("e_c11_req", imem_req, 1);
        chk("e_c11_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        advance(); settle();
        chk("e_c12_addr", imem_addr, 64'h0);
        advance(); settle();
        check_head("e_c13", 64'hFFFF_FFFF_FFFF_FFFC);
        advance(); settle();
        check_head("e_c14", 64'h0);
        chk("e_c14_addr", imem_addr, 64'h8);
        mem_lat = 4;

        // reset mid-flight; the late response must be ignored
        advance(); reset = 1'b0; settle();
        chk("f_rst_req", imem_req, 0);
        chk("f_rst_valid", instr_valid_IF, 0);
        chk("f_rst_pc", pc_IF, 0);
        chk("f_rst_instr", instr_IF, 0);
        advance(); settle();
        advance(); reset = 1'b1; settle();
        chk("f_r0_req", imem_req, 1);
        chk("f_r0_addr", imem_addr, 64'h0);
        advance(); settle();
        chk("f_r1_rvalid_late", imem_rvalid, 1);
        chk("f_r1_valid", instr_valid_IF, 0);
        mem_lat = 1;
        advance(); settle();
        chk("f_r2_valid", instr_valid_IF, 0);
        advance(); settle();
        check_head("f_r3", 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipeline_if_stage.md
# pipeline_if_stage

Instruction-fetch stage at the front of the 5-stage pipeline. It owns the fetch PC and issues sequential instruction-memory requests. It buffers returned instructions in a small fetch queue and presents them to the IDR stage. It is the consumer of the EXB redirect: `branch_taken_EXB` / `branch_target_EXB` retarget fetch, purge queued and in-flight wrong-path instructions, and restart fetching at the target.

## Interface
- `RESET_PC`, default `64'h0`: first fetch address after reset.
- `FQ_DEPTH`, default `4`: fetch-queue entries, power of two, ≥2.

- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-low.
- `stall` in 1: downstream stall; holds the queue head.
- `branch_taken_EXB` in 1: redirect request from EXB, combinational in the same cycle.
- `branch_target_EXB` in 64: redirect target.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 64: fetch address, always 4-byte aligned.
- `imem_gnt` in 1: memory accepts the request this cycle.
- `imem_rvalid` in 1: response valid, no earlier than the cycle after grant.
- `imem_rdata` in 32: response instruction.
- `instr_valid_IF` out 1: head entry valid for IDR.
- `pc_IF` out 64: PC of head entry.
- `instr_IF` out 32: instruction of head entry.

## Operation
- State:
  - `fetch_pc`
  - queue of {pc, instr}
  - `outst`: one request in flight
  - `outst_pc`
  - `stale`: the in-flight response is to be discarded
- At most one outstanding request.
- `live = outst & ~stale`.
- `imem_req = ~branch_taken_EXB & (~outst | imem_rvalid) & (count + live < FQ_DEPTH)`.
  - A same-cycle pop is not credited; space accounting is conservative.
- `imem_addr = fetch_pc`.
- On request and grant:
  - `outst` ← 1, `stale` ← 0, `outst_pc` ← `fetch_pc`.
  - `fetch_pc` ← `fetch_pc + 4`, modulo 2^64.
- On `imem_rvalid` with `outst`:
  - `outst` ← 0 unless a new grant occurs in the same cycle.
  - If `~stale`, push {`outst_pc`, `imem_rdata`}.
  - If `stale`, drop the response.
- `imem_rvalid` with `outst`=0 is ignored.
- Pop the head when `instr_valid_IF & ~stall`.
- Redirect (`branch_taken_EXB`=1) has priority over everything, including `stall`:
  - Queue cleared.
  - `fetch_pc` ← {`branch_target_EXB[63:2]`, 2'b00}.
  - If `outst` and no `imem_rvalid` this cycle, `stale` ← 1.
  - No push or pop this cycle.
- `instr_valid_IF = (count != 0) & ~branch_taken_EXB`.
- `pc_IF` and `instr_IF` are 0 whenever `instr_valid_IF`=0.
- Reset mid-operation clears everything. A response arriving after reset deassertion with `outst`=0 is ignored.

## Timing
- Reset values:
  - `imem_req`=0 while reset is asserted.
  - `instr_valid_IF`=0, `pc_IF`=0, `instr_IF`=0.
  - `fetch_pc`=`RESET_PC`; `outst`, `stale`, `count` = 0.
- First cycle after reset release: `imem_req`=1, `imem_addr`=`RESET_PC`.
- Latency with 1-cycle memory (grant in cycle G):
  - `rvalid` in G+1.
  - Entry visible at `instr_valid_IF` in G+2.
- Throughput: one fetch per cycle while the queue is below `FQ_DEPTH`−1 and not stalled.
- Redirect in cycle N, nothing in flight:
  - `imem_req`=0 in N.
  - `imem_req` with target in N+1.
  - First target instruction valid in N+3.
- Redirect with a stale request in flight: the new request is issued in the cycle the stale `rvalid` arrives.
- Queue full and `stall` held: `imem_req`=0, outputs held stable.
- Simultaneous push and pop: `count` unchanged.
- Simultaneous `rvalid` and grant: allowed.

## Structure
- Shared package `pipeline_pkg`:
  - `fetch_entry_t` struct {`logic [63:0] pc`; `logic [31:0] instr`}.
  - `INSTR_NOP` constant (`32'h00000013`).
  - Default `RESET_PC`.
- Sub-module `fetch_queue`: synchronous FIFO of `fetch_entry_t`.
  - Ports: push, pop, clear, head, count.
  - Clear has priority over push and pop.
- Top module: PC register, outstanding/stale tracking, request logic.

## Test plan
- Reset release, memory always grants, 1-cycle `rvalid` → requests at 0x0, 0x4, 0x8, …; `pc_IF` sequence 0x0, 0x4, 0x8 with `instr_valid_IF` from cycle 2 after release.
- `stall` held 10 cycles → queue fills to 4, `imem_req` drops, head stays `pc_IF`=0x0; release → 0x0…0xC drain in order with no loss or duplication.
- Redirect to 0x100 while the queue holds 0x8, 0xC and nothing is in flight → `instr_valid_IF`=0 that cycle; next request addr 0x100; next valid `pc_IF`=0x100.
- Redirect to 0x200 while request 0x10 is granted and `rvalid` arrives 3 cycles later → 0x10 instruction never appears; first valid `pc_IF`=0x200.
- Redirect target 0x203 → `imem_addr`=0x200.
- Redirect together with `stall`=1 → queue cleared anyway.
- `fetch_pc`=0xFFFF_FFFF_FFFF_FFFC granted → next request addr 0x0.
- Reset asserted mid-flight, then `rvalid` arrives after release → response ignored; fetch restarts at `RESET_PC`.
